simp_fun_stream: RTL and testbench

Parametrised successor to the basic two-operand pipelined function block. Adds a selectable operation, optional saturation, an overflow flag, a MAC accumulator and valid/ready flow control with backpressure. Sits between an operand producer and a result consumer in the basic_logic datapath demos. Pipeline depth is configurable.

---
 rtl/simp_fun_pkg.sv | 20 ++
 rtl/simp_fun_alu.sv | 57 +++++
 rtl/simp_fun_stream.sv | 122 ++++++++++++
 tb/tb_simp_fun_stream.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/simp_fun_pkg.sv
// Shared types for the simp_fun streaming function block.
package simp_fun_pkg;

  localparam int unsigned OP_W      = 2;
  localparam int unsigned MAX_WIDTH = 64;

  typedef enum logic [OP_W-1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    MAC = 2'd3
  } op_t;

  // Packages cannot be parameterised, so data is sized for the widest supported WIDTH.
  typedef struct packed {
    logic [MAX_WIDTH-1:0] data;
    logic                 ovf;
  } result_t;

endpackage

// File: rtl/simp_fun_alu.sv
// Combinational operator: ADD/SUB/MUL/MAC with overflow detect and optional clamping.
module simp_fun_alu
  import simp_fun_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned SATURATE = 0
) (
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  op_t              op_in,
  input  logic [WIDTH-1:0] acc_in,
  input  logic             acc_clr_in,
  output logic [WIDTH-1:0] result_out,
  output logic             ovf_out,
  output logic [WIDTH-1:0] acc_next_out
);

  logic [WIDTH:0]       sum_w;
  logic [2*WIDTH-1:0]   prod_w;
  logic [2*WIDTH:0]     mac_w;
  logic [WIDTH-1:0]     acc_base;
  logic [WIDTH-1:0]     raw;

  always_comb begin
    sum_w    = {1'b0, a_in} + {1'b0, b_in};
    prod_w   = {{WIDTH{1'b0}}, a_in} * {{WIDTH{1'b0}}, b_in};
    acc_base = acc_clr_in ? '0 : acc_in;
    mac_w    = {{(WIDTH+1){1'b0}}, acc_base} + {1'b0, prod_w};
    raw      = '0;
    ovf_out  = 1'b0;
    unique case (op_in)
      ADD: begin
        raw     = sum_w[WIDTH-1:0];
        ovf_out = sum_w[WIDTH];
      end
      SUB: begin
        raw     = a_in - b_in;
        ovf_out = (a_in < b_in);
      end
      MUL: begin
        raw     = prod_w[WIDTH-1:0];
        ovf_out = |prod_w[2*WIDTH-1:WIDTH];
      end
      MAC: begin
        raw     = mac_w[WIDTH-1:0];
        ovf_out = |mac_w[2*WIDTH:WIDTH];
      end
      default: ;
    endcase
    result_out = raw;
    if ((SATURATE != 0) && ovf_out) begin
      result_out = (op_in == SUB) ? '0 : '1;
    end
    acc_next_out = (op_in == MAC) ? result_out : acc_in;
  end

endmodule

// File: rtl/simp_fun_stream.sv
// Pipelined two-operand function block with MAC accumulator and valid/ready backpressure.
module simp_fun_stream
  import simp_fun_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned LATENCY  = 2,
  parameter int unsigned SATURATE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  input  logic [OP_W-1:0]   op_in,
  input  logic              acc_clr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  c_out,
  output logic              ovf_out
);

  localparam int unsigned NR = LATENCY - 1;

  logic             advance;
  logic             v1_q, v1_d;
  logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
  op_t              op1_q, op1_d;
  logic             clr1_q, clr1_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             rv_q [NR];
  logic             rv_d [NR];
  logic [WIDTH-1:0] rd_q [NR];
  logic [WIDTH-1:0] rd_d [NR];
  logic             ro_q [NR];
  logic             ro_d [NR];

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH-1:0] alu_acc_next;

  simp_fun_alu #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_alu (
    .a_in         (a1_q),
    .b_in         (b1_q),
    .op_in        (op1_q),
    .acc_in       (acc_q),
    .acc_clr_in   (clr1_q),
    .result_out   (alu_res),
    .ovf_out      (alu_ovf),
    .acc_next_out (alu_acc_next)
  );

  assign out_valid = rv_q[NR-1];
  assign c_out     = rd_q[NR-1];
  assign ovf_out   = ro_q[NR-1];
  assign in_ready  = advance;

  always_comb begin
    advance = !rv_q[NR-1] || out_ready;
    v1_d    = v1_q;
    a1_d    = a1_q;
    b1_d    = b1_q;
    op1_d   = op1_q;
    clr1_d  = clr1_q;
    acc_d   = acc_q;
    rv_d    = rv_q;
    rd_d    = rd_q;
    ro_d    = ro_q;
    if (advance) begin
      v1_d   = in_valid;
      a1_d   = a_in;
      b1_d   = b_in;
      op1_d  = op_t'(op_in);
      clr1_d = acc_clr_in;
      rv_d[0] = v1_q;
      rd_d[0] = alu_res;
      ro_d[0] = alu_ovf;
      for (int unsigned i = 1; i < NR; i++) begin
        rv_d[i] = rv_q[i-1];
        rd_d[i] = rd_q[i-1];
        ro_d[i] = ro_q[i-1];
      end
      // The accumulator commits only as a valid MAC beat leaves stage 1, so stalls cannot double-count.
      if (v1_q && (op1_q == MAC)) begin
        acc_d = alu_acc_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      op1_q  <= ADD;
      clr1_q <= 1'b0;
      acc_q  <= '0;
      for (int unsigned i = 0; i < NR; i++) begin
        rv_q[i] <= 1'b0;
        rd_q[i] <= '0;
        ro_q[i] <= 1'b0;
      end
    end else begin
      v1_q   <= v1_d;
      a1_q   <= a1_d;
      b1_q   <= b1_d;
      op1_q  <= op1_d;
      clr1_q <= clr1_d;
      acc_q  <= acc_d;
      for (int unsigned i = 0; i < NR; i++) begin
        rv_q[i] <= rv_d[i];
        rd_q[i] <= rd_d[i];
        ro_q[i] <= ro_d[i];
      end
    end
  end

endmodule

// File: tb/tb_simp_fun_stream.sv
// Directed bench: wrap and saturating LATENCY=2 instances share stimulus; a LATENCY=4 instance checks depth.
module tb_simp_fun_stream;
  import simp_fun_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic [1:0]  op;
  logic        clr;
  logic        out_ready;

  logic        in_ready_w, out_valid_w, ovf_w;
  logic [15:0] c_w;
  logic        in_ready_s, out_valid_s, ovf_s;
  logic [15:0] c_s;
  logic        in_valid_l, in_ready_l, out_valid_l, ovf_l;
  logic [15:0] c_l;

  int n_pass = 0;
  int n_tot  = 0;

  simp_fun_stream #(.WIDTH(16), .LATENCY(2), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .a_in(a), .b_in(b), .op_in(op), .acc_clr_in(clr),
    .out_valid(out_valid_w), .out_ready(out_ready), .c_out(c_w), .ovf_out(ovf_w)
  );

  simp_fun_stream #(.WIDTH(16), .LATENCY(2), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .a_in(a), .b_in(b), .op_in(op), .acc_clr_in(clr),
    .out_valid(out_valid_s), .out_ready(out_ready), .c_out(c_s), .ovf_out(ovf_s)
  );

  simp_fun_stream #(.WIDTH(16), .LATENCY(4), .SATURATE(0)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid_l), .in_ready(in_ready_l),
    .a_in(a), .b_in(b), .op_in(op), .acc_clr_in(clr),
    .out_valid(out_valid_l), .out_ready(1'b1), .c_out(c_l), .ovf_out(ovf_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    op_t         op;
    logic [15:0] a;
    logic [15:0] b;
    logic        clr;
    logic [15:0] cw;
    logic        ow;
    logic [15:0] cs;
    logic        os;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input op_t o, input logic [15:0] x, input logic [15:0] y, input logic c);
    op  = o;
    a   = x;
    b   = y;
    clr = c;
  endtask

  // Streams the table back to back with out_ready high; row i is checked one edge after its accept.
  task automatic run_table();
    out_ready = 1'b1;
    for (int i = 0; i <= tbl.size(); i++) begin
      if (i < tbl.size()) begin
        in_valid = 1'b1;
        drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].clr);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i == 0) begin
        chk("first_not_early", out_valid_w, 0);
      end else begin
        chk($sformatf("row%0d_valid", i-1), out_valid_w, 1);
        chk($sformatf("row%0d_c_wrap", i-1), c_w, tbl[i-1].cw);
        chk($sformatf("row%0d_ovf_wrap", i-1), ovf_w, tbl[i-1].ow);
        chk($sformatf("row%0d_c_sat", i-1), c_s, tbl[i-1].cs);
        chk($sformatf("row%0d_ovf_sat", i-1), ovf_s, tbl[i-1].os);
      end
    end
  endtask

  task automatic run_backpressure(input logic use_mac);
    logic [11:0] pat;
    logic [15:0] exp_c [4];
    int          sent;
    int          rcv;
    logic        acc_in;
    logic        take_out;
    logic        prev_stall;
    logic [15:0] prev_c;
    pat = 12'b1111_0010_1001;
    if (use_mac) begin
      exp_c[0] = 16'd1;  exp_c[1] = 16'd5;  exp_c[2] = 16'd14; exp_c[3] = 16'd30;
    end else begin
      exp_c[0] = 16'd2;  exp_c[1] = 16'd4;  exp_c[2] = 16'd6;  exp_c[3] = 16'd8;
    end
    sent = 0;
    rcv = 0;
    prev_stall = 1'b0;
    prev_c = '0;
    for (int cyc = 0; cyc < 40 && rcv < 4; cyc++) begin
      out_ready = (cyc < 12) ? pat[cyc] : 1'b1;
      in_valid  = (sent < 4);
      drive(use_mac ? MAC : ADD, 16'(sent + 1), 16'(sent + 1), use_mac && (sent == 0));
      #1;
      chk("bp_in_ready", in_ready_w, !(out_valid_w && !out_ready));
      if (prev_stall) begin
        chk("bp_hold_valid", out_valid_w, 1);
        chk("bp_hold_c", c_w, prev_c);
      end
      acc_in   = in_valid && in_ready_w;
      take_out = out_valid_w && out_ready;
      if (take_out && rcv < 4) begin
        chk($sformatf("bp_res%0d_wrap", rcv), c_w, exp_c[rcv]);
        chk($sformatf("bp_res%0d_sat", rcv), c_s, exp_c[rcv]);
        rcv++;
      end
      prev_stall = out_valid_w && !out_ready;
      prev_c     = c_w;
      @(posedge clk);
      if (acc_in) sent++;
      #1;
    end
    chk("bp_delivered", rcv, 4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_no_dup", out_valid_w, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_valid_l = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0; clr = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", out_valid_w, 0);
    chk("rst_c_out", c_w, 0);
    chk("rst_ovf", ovf_w, 0);
    chk("rst_in_ready", in_ready_w, 1);
    chk("rst_l_out_valid", out_valid_l, 0);

    tbl.push_back('{ADD, 16'd5,     16'd7,     1'b0, 16'd12,    1'b0, 16'd12,    1'b0});
    tbl.push_back('{SUB, 16'd100,   16'd50,    1'b0, 16'd50,    1'b0, 16'd50,    1'b0});
    tbl.push_back('{MUL, 16'd10,    16'd20,    1'b0, 16'd200,   1'b0, 16'd200,   1'b0});
    tbl.push_back('{ADD, 16'd65535, 16'd1,     1'b0, 16'd0,     1'b1, 16'd65535, 1'b1});
    tbl.push_back('{SUB, 16'd0,     16'd1,     1'b0, 16'd65535, 1'b1, 16'd0,     1'b1});
    tbl.push_back('{MUL, 16'd256,   16'd256,   1'b0, 16'd0,     1'b1, 16'd65535, 1'b1});
    tbl.push_back('{MAC, 16'd3,     16'd4,     1'b1, 16'd12,    1'b0, 16'd12,    1'b0});
    tbl.push_back('{MAC, 16'd5,     16'd6,     1'b0, 16'd42,    1'b0, 16'd42,    1'b0});
    tbl.push_back('{MAC, 16'd1,     16'd1,     1'b0, 16'd43,    1'b0, 16'd43,    1'b0});
    tbl.push_back('{ADD, 16'd1,     16'd1,     1'b0, 16'd2,     1'b0, 16'd2,     1'b0});
    tbl.push_back('{MAC, 16'd1,     16'd1,     1'b0, 16'd44,    1'b0, 16'd44,    1'b0});
    tbl.push_back('{MAC, 16'd2,     16'd2,     1'b1, 16'd4,     1'b0, 16'd4,     1'b0});
    tbl.push_back('{MAC, 16'd255,   16'd255,   1'b1, 16'd65025, 1'b0, 16'd65025, 1'b0});
    tbl.push_back('{MAC, 16'd255,   16'd2,     1'b0, 16'd65535, 1'b0, 16'd65535, 1'b0});
    tbl.push_back('{MAC, 16'd1,     16'd1,     1'b0, 16'd0,     1'b1, 16'd65535, 1'b1});
    tbl.push_back('{MAC, 16'd1,     16'd1,     1'b0, 16'd1,     1'b0, 16'd65535, 1'b1});
    tbl.push_back('{SUB, 16'd7,     16'd7,     1'b0, 16'd0,     1'b0, 16'd0,     1'b0});
    tbl.push_back('{MUL, 16'd65535, 16'd65535, 1'b0, 16'd1,     1'b1, 16'd65535, 1'b1});
    run_table();
    step();

    run_backpressure(1'b0);
    step();
    run_backpressure(1'b1);
    step();

    // Reset lands while two beats are in flight and the accumulator holds 25.
    out_ready = 1'b1;
    in_valid = 1'b1;
    drive(MAC, 16'd5, 16'd5, 1'b1);
    step();
    drive(ADD, 16'd1, 16'd1, 1'b0);
    step();
    rst = 1'b1;
    drive(ADD, 16'd9, 16'd9, 1'b0);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("midrst_out_valid", out_valid_w, 0);
    chk("midrst_c_out", c_w, 0);
    chk("midrst_ovf", ovf_w, 0);
    chk("midrst_in_ready", in_ready_w, 1);
    step();
    chk("midrst_no_leak", out_valid_w, 0);
    in_valid = 1'b1;
    drive(MAC, 16'd2, 16'd3, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    chk("midrst_acc_valid", out_valid_w, 1);
    chk("midrst_acc_wrap", c_w, 6);
    chk("midrst_acc_sat", c_s, 6);
    step();

    in_valid_l = 1'b1;
    drive(ADD, 16'd10, 16'd20, 1'b0);
    step();
    in_valid_l = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k < 2) begin
        chk($sformatf("lat4_early%0d", k), out_valid_l, 0);
        step();
      end else begin
        chk("lat4_early2", out_valid_l, 0);
        step();
        chk("lat4_valid", out_valid_l, 1);
        chk("lat4_c", c_l, 30);
        chk("lat4_ovf", ovf_l, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
